mux2_rr_arbiter: RTL



---
 rtl/mux2_rr_arbiter_if.sv | 26 ++
 rtl/mux2_rr_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter_if.sv
// Requester/mux bundle for the 2-way round-robin arbiter.
// master: arbiter side; slave: requesters and downstream sink.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req_x;
  logic [WIDTH-1:0] data_x;
  logic             req_y;
  logic [WIDTH-1:0] data_y;
  logic             gnt_x;
  logic             gnt_y;
  logic             sel;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             busy;

  modport master (
    input  req_x, data_x, req_y, data_y,
    output gnt_x, gnt_y, sel, m_data, m_valid, busy
  );

  modport slave (
    output req_x, data_x, req_y, data_y,
    input  gnt_x, gnt_y, sel, m_data, m_valid, busy
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux, bounded bursts, registered output.
// Ports: clk, rst_n (async low), bus (req/data in, gnt/sel/m_data/m_valid/busy out).
module mux2_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux2_rr_arbiter_if.master bus
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_X = 2'd1,
    OWN_Y = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;

  logic   own_y;
  logic   beat;
  logic   oth_req;
  state_t oth_st;

  always_comb begin
    own_y   = (state_q == OWN_Y);
    beat    = ((state_q == OWN_X) & bus.req_x) |
              ((state_q == OWN_Y) & bus.req_y);
    oth_req = own_y ? bus.req_x : bus.req_y;
    oth_st  = own_y ? OWN_X : OWN_Y;

    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req_x & bus.req_y)
          state_d = last_q ? OWN_X : OWN_Y;
        else if (bus.req_x)
          state_d = OWN_X;
        else if (bus.req_y)
          state_d = OWN_Y;
      end
      OWN_X, OWN_Y: begin
        if (beat) begin
          if (cnt_q == CMAX) begin
            // Quantum spent: hand over only if the other side waits.
            cnt_d = '0;
            if (oth_req) begin
              state_d = oth_st;
              last_d  = own_y;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // Owner released the mux.
          cnt_d   = '0;
          last_d  = own_y;
          state_d = oth_req ? oth_st : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    sel_d = sel_q;
    if (state_d == OWN_Y)
      sel_d = 1'b1;
    else if (state_d == OWN_X)
      sel_d = 1'b0;

    m_valid_d = beat;
    m_data_d  = m_data_q;
    if (beat)
      m_data_d = own_y ? bus.data_y : bus.data_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign bus.gnt_x   = (state_q == OWN_X);
  assign bus.gnt_y   = (state_q == OWN_Y);
  assign bus.busy    = (state_q == OWN_X) | (state_q == OWN_Y);
  assign bus.sel     = sel_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;

endmodule
